// File: rtl/serial_demux_engine.sv
// serial_demux_engine
// Serial frame receiver/demultiplexer. A frame is a low start bit, a
// PORT_BITS-wide address, a LEN_BITS-wide length, then <length> payload
// bits. Payload bits are routed to lane Port with a per-lane valid strobe.
// Done pulses one enabled cycle after the last payload/length bit.
// Optional feature: define SERDEMUX_PARITY_EN to add an even-parity bit
// after the payload. A parity mismatch is reported on ParErr together
// with Done.
module serial_demux_engine #(
    parameter int unsigned PORT_BITS = 2,
    parameter int unsigned LEN_BITS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clkEn,
    input  logic                      SerIn,
    output logic [2**PORT_BITS-1:0]   SerOut,
    output logic [2**PORT_BITS-1:0]   SerOutValid,
    output logic [PORT_BITS-1:0]      Port,
    output logic                      Busy,
    output logic                      Done,
    output logic                      ParErr
);

    localparam int unsigned FLD_MAX = (PORT_BITS > LEN_BITS) ? PORT_BITS : LEN_BITS;
    localparam int unsigned CNT_W   = $clog2(FLD_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(PORT_BITS - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef SERDEMUX_PARITY_EN
        S_PAR,
`endif
        S_DONE
    } state_t;

    // State entered once the payload (possibly empty) has been consumed
`ifdef SERDEMUX_PARITY_EN
    localparam state_t AFTER_PAYLOAD = S_PAR;
`else
    localparam state_t AFTER_PAYLOAD = S_DONE;
`endif

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [PORT_BITS-1:0]   r_addr;
    logic [PORT_BITS-1:0]   r_port;
    logic [LEN_BITS-1:0]    r_len;
    logic [LEN_BITS-1:0]    r_data_cnt;

    logic [PORT_BITS-1:0]   w_addr_shift;
    logic [LEN_BITS-1:0]    w_len_shift;
    logic                   w_addr_last;
    logic                   w_len_last;
    logic                   w_data_last;
    logic                   w_par_err;

    // MSB-first shift: the incoming bit enters at the LSB
    assign w_addr_shift = PORT_BITS'({r_addr, SerIn});
    assign w_len_shift  = LEN_BITS'({r_len, SerIn});
    assign w_addr_last  = (r_bit_cnt == ADDR_LAST);
    assign w_len_last   = (r_bit_cnt == LEN_LAST);
    assign w_data_last  = (r_data_cnt == LEN_BITS'(1));
    assign Port         = r_port;

    // State register; reset wins over clkEn
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; holds whenever clkEn is low
    always_comb begin
        w_next_state = r_state;
        if (clkEn) begin
            case (r_state)
                S_IDLE: begin
                    if (!SerIn) begin
                        w_next_state = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_addr_last) begin
                        w_next_state = S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_len_last) begin
                        w_next_state = (w_len_shift == '0) ? AFTER_PAYLOAD : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_data_last) begin
                        w_next_state = AFTER_PAYLOAD;
                    end
                end
`ifdef SERDEMUX_PARITY_EN
                S_PAR: begin
                    w_next_state = S_DONE;
                end
`endif
                S_DONE: begin
                    w_next_state = SerIn ? S_IDLE : S_ADDR;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Field shift registers, bit counter, data counter and latched port
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt  <= '0;
            r_addr     <= '0;
            r_port     <= '0;
            r_len      <= '0;
            r_data_cnt <= '0;
        end else if (clkEn) begin
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= '0;
                end
                S_ADDR: begin
                    r_addr <= w_addr_shift;
                    if (w_addr_last) begin
                        r_bit_cnt <= '0;
                        r_port    <= w_addr_shift;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                S_LEN: begin
                    r_len <= w_len_shift;
                    if (w_len_last) begin
                        r_bit_cnt  <= '0;
                        r_data_cnt <= w_len_shift;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    r_data_cnt <= r_data_cnt - LEN_BITS'(1);
                end
                default: begin
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

`ifdef SERDEMUX_PARITY_EN
    logic r_par_acc;
    logic r_par_err;

    // Running XOR of the payload, compared against the received parity bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_par_acc <= 1'b0;
            r_par_err <= 1'b0;
        end else if (clkEn) begin
            case (r_state)
                S_LEN:   r_par_acc <= 1'b0;
                S_DATA:  r_par_acc <= r_par_acc ^ SerIn;
                S_PAR:   r_par_err <= r_par_acc ^ SerIn;
                default: r_par_acc <= r_par_acc;
            endcase
        end
    end

    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    // Output decode: lane routing is combinational from state, Port and SerIn
    always_comb begin
        SerOut      = '0;
        SerOutValid = '0;
        Done        = 1'b0;
        ParErr      = 1'b0;
        Busy        = (r_state != S_IDLE);
        if (r_state == S_DATA) begin
            SerOut[r_port]      = SerIn;
            SerOutValid[r_port] = clkEn;
        end
        if (r_state == S_DONE) begin
            Done   = clkEn;
            ParErr = clkEn & w_par_err;
        end
    end

endmodule
